// File: rtl/gig_eth_rx_frame_fifo.sv
// Store-and-forward RX frame buffer behind the GMII MAC: speculative byte writes,
// commit on goodframe, rewind on bad/overflow, valid/ready byte stream out.
module gig_eth_rx_frame_fifo #(
  parameter int ADDR_W     = 14,
  parameter int LEN_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic             rx_clk,
  input  logic             reset,
  input  logic [7:0]       mac_rx_data,
  input  logic             mac_rx_dvld,
  input  logic             mac_rx_goodframe,
  input  logic             mac_rx_badframe,
  output logic [7:0]       rx_fifo_data,
  output logic             rx_fifo_valid,
  output logic             rx_fifo_last,
  input  logic             rx_fifo_ready,
  output logic [CNT_W-1:0] rx_drop_count,
  output logic [CNT_W-1:0] rx_bad_count
);

  localparam int PW    = ADDR_W + 1;
  localparam int LEN_D = 1 << LEN_ADDR_W;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {WR_IDLE, WR_FRAME, WR_DROP} wr_state_t;

  wr_state_t state, state_nx;

  logic [7:0]    mem [2**ADDR_W];
  logic [PW-1:0] len_mem [LEN_D];

  logic [PW-1:0] wr_ptr, wr_ptr_nx, cmt_ptr, cmt_ptr_nx, rd_ptr;
  logic [PW-1:0] len, len_nx, remaining, rem_src;
  logic [LEN_ADDR_W-1:0] len_wa, len_ra;
  logic [LEN_ADDR_W:0]   len_cnt;
  logic space, len_full, len_empty;
  logic wr_en, push, pop, load, avail, drop_inc, bad_inc;

  assign space     = (wr_ptr - rd_ptr) != DEPTH;
  assign len_full  = len_cnt[LEN_ADDR_W];
  assign len_empty = (len_cnt == '0);

  // A strobe coincident with a data byte acts on the state after that byte.
  always_comb begin
    state_nx   = state;
    wr_ptr_nx  = wr_ptr;
    cmt_ptr_nx = cmt_ptr;
    len_nx     = len;
    wr_en      = 1'b0;
    push       = 1'b0;
    drop_inc   = 1'b0;
    bad_inc    = 1'b0;
    if (mac_rx_dvld && state != WR_DROP) begin
      if (space) begin
        wr_en     = 1'b1;
        wr_ptr_nx = wr_ptr + 1'b1;
        len_nx    = (state == WR_IDLE) ? PW'(1) : len + 1'b1;
        state_nx  = WR_FRAME;
      end else begin
        state_nx = WR_DROP;
      end
    end
    if (mac_rx_goodframe) begin
      if (state_nx == WR_FRAME && !len_full) begin
        push       = 1'b1;
        cmt_ptr_nx = wr_ptr_nx;
      end else if (state_nx != WR_IDLE) begin
        wr_ptr_nx = cmt_ptr;
        drop_inc  = 1'b1;
      end
      state_nx = WR_IDLE;
    end else if (mac_rx_badframe) begin
      bad_inc = 1'b1;
      if (state_nx != WR_IDLE) wr_ptr_nx = cmt_ptr;
      state_nx = WR_IDLE;
    end
  end

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      state         <= WR_IDLE;
      wr_ptr        <= '0;
      cmt_ptr       <= '0;
      len           <= '0;
      rx_drop_count <= '0;
      rx_bad_count  <= '0;
    end else begin
      state   <= state_nx;
      wr_ptr  <= wr_ptr_nx;
      cmt_ptr <= cmt_ptr_nx;
      len     <= len_nx;
      if (drop_inc && !(&rx_drop_count)) rx_drop_count <= rx_drop_count + 1'b1;
      if (bad_inc && !(&rx_bad_count))   rx_bad_count  <= rx_bad_count + 1'b1;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= mac_rx_data;
    if (push)  len_mem[len_wa] <= len_nx;
  end

  // Reader only ever looks at committed data: the length FIFO and remaining.
  assign avail   = (remaining != '0) || !len_empty;
  assign load    = avail && (!rx_fifo_valid || rx_fifo_ready);
  assign pop     = load && (remaining == '0);
  assign rem_src = pop ? len_mem[len_ra] : remaining;

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      len_wa  <= '0;
      len_ra  <= '0;
      len_cnt <= '0;
    end else begin
      if (push) len_wa <= len_wa + 1'b1;
      if (pop)  len_ra <= len_ra + 1'b1;
      case ({push, pop})
        2'b10:   len_cnt <= len_cnt + 1'b1;
        2'b01:   len_cnt <= len_cnt - 1'b1;
        default: len_cnt <= len_cnt;
      endcase
    end
  end

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      rd_ptr        <= '0;
      remaining     <= '0;
      rx_fifo_data  <= '0;
      rx_fifo_valid <= 1'b0;
      rx_fifo_last  <= 1'b0;
    end else if (load) begin
      rd_ptr        <= rd_ptr + 1'b1;
      remaining     <= rem_src - 1'b1;
      rx_fifo_data  <= mem[rd_ptr[ADDR_W-1:0]];
      rx_fifo_valid <= 1'b1;
      rx_fifo_last  <= (rem_src == PW'(1));
    end else if (rx_fifo_ready) begin
      rx_fifo_valid <= 1'b0;
      rx_fifo_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gig_eth_rx_frame_fifo.sv
// Directed bench for gig_eth_rx_frame_fifo: three parameterisations share one stimulus
// bus; sel picks which instance is observed by the output monitor.
module tb_gig_eth_rx_frame_fifo;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] din;
  logic dvld, good, bad, ready;
  logic [7:0] d0, d1, d2;
  logic v0, v1, v2, l0, l1, l2;
  logic [15:0] dr0, dr1, dr2, bc0, bc1, bc2;

  gig_eth_rx_frame_fifo dut0 (
    .rx_clk(clk), .reset(reset), .mac_rx_data(din), .mac_rx_dvld(dvld),
    .mac_rx_goodframe(good), .mac_rx_badframe(bad), .rx_fifo_data(d0),
    .rx_fifo_valid(v0), .rx_fifo_last(l0), .rx_fifo_ready(ready),
    .rx_drop_count(dr0), .rx_bad_count(bc0));

  gig_eth_rx_frame_fifo #(.ADDR_W(8)) dut1 (
    .rx_clk(clk), .reset(reset), .mac_rx_data(din), .mac_rx_dvld(dvld),
    .mac_rx_goodframe(good), .mac_rx_badframe(bad), .rx_fifo_data(d1),
    .rx_fifo_valid(v1), .rx_fifo_last(l1), .rx_fifo_ready(ready),
    .rx_drop_count(dr1), .rx_bad_count(bc1));

  gig_eth_rx_frame_fifo #(.LEN_ADDR_W(1)) dut2 (
    .rx_clk(clk), .reset(reset), .mac_rx_data(din), .mac_rx_dvld(dvld),
    .mac_rx_goodframe(good), .mac_rx_badframe(bad), .rx_fifo_data(d2),
    .rx_fifo_valid(v2), .rx_fifo_last(l2), .rx_fifo_ready(ready),
    .rx_drop_count(dr2), .rx_bad_count(bc2));

  int sel = 0;
  logic [7:0] sd;
  logic sv, sl;
  logic [15:0] sdrop, sbad;

  always_comb begin
    sd = d0; sv = v0; sl = l0; sdrop = dr0; sbad = bc0;
    case (sel)
      1: begin sd = d1; sv = v1; sl = l1; sdrop = dr1; sbad = bc1; end
      2: begin sd = d2; sv = v2; sl = l2; sdrop = dr2; sbad = bc2; end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;
  logic [7:0] q_data[$];
  bit q_last[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs settle #1 after posedge, so at negedge valid&&ready means a transfer at the next edge.
  logic stall_p = 1'b0;
  logic [7:0] data_p = '0;
  logic last_p = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      stall_p <= 1'b0;
    end else begin
      if (stall_p) begin
        chk("hold_valid", 32'(sv), 1);
        chk("hold_data", 32'(sd), 32'(data_p));
        chk("hold_last", 32'(sl), 32'(last_p));
      end
      if (sv && ready) begin
        q_data.push_back(sd);
        q_last.push_back(sl);
      end
      stall_p <= sv && !ready;
      data_p  <= sd;
      last_p  <= sl;
    end
  end

  task automatic step();
    if (rand_ready) ready = ($urandom_range(0, 3) != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic dv, input logic [7:0] d, input logic g, input logic b);
    dvld = dv; din = d; good = g; bad = b;
    step();
    dvld = 1'b0; din = 8'h00; good = 1'b0; bad = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] seed, input bit is_bad);
    for (int i = 0; i < n; i++) cyc(1'b1, seed + 8'(i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, !is_bad, is_bad);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k;
    k = 0;
    while (q_data.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic check_frame(input string name, input int n, input logic [7:0] seed);
    int derr, lerr;
    logic [7:0] exp_b;
    derr = 0; lerr = 0;
    if (q_data.size() < n) begin
      chk({name, "_len"}, q_data.size(), n);
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_b = seed + 8'(i);
      if (q_data.pop_front() !== exp_b) derr++;
      if (q_last.pop_front() !== (i == n - 1)) lerr++;
    end
    chk({name, "_data_err"}, derr, 0);
    chk({name, "_last_err"}, lerr, 0);
  endtask

  task automatic do_reset(input int s);
    reset = 1'b1;
    sel = s;
    dvld = 1'b0; din = 8'h00; good = 1'b0; bad = 1'b0; ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    q_data.delete();
    q_last.delete();
  endtask

  typedef struct {
    logic dv; logic [7:0] d; logic g; logic b;
    logic exp_v; logic [7:0] exp_d; logic exp_l; int exp_bad; int exp_drop;
  } vec_t;
  vec_t tbl[12];

  int lens[20];
  logic [7:0] seeds[20];
  int total;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // Short-frame and strobe corner cases; outputs are those after the edge that sampled the row.
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1, 0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1, 0};
    tbl[2]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1, 0};
    tbl[3]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1, 0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1, 0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1, 0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1, 0};
    tbl[7]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2, 0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2, 0};
    tbl[9]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2, 0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 2, 0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2, 0};

    dvld = 1'b0; din = 8'h00; good = 1'b0; bad = 1'b0; ready = 1'b0;
    reset = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(sv), 0);
    chk("rst_data", 32'(sd), 0);
    chk("rst_last", 32'(sl), 0);
    chk("rst_drop", 32'(sdrop), 0);
    chk("rst_bad", 32'(sbad), 0);
    reset = 1'b0;

    ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].dv, tbl[i].d, tbl[i].g, tbl[i].b);
      chk($sformatf("vec%0d_valid", i), 32'(sv), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) begin
        chk($sformatf("vec%0d_data", i), 32'(sd), 32'(tbl[i].exp_d));
        chk($sformatf("vec%0d_last", i), 32'(sl), 32'(tbl[i].exp_l));
      end
      chk($sformatf("vec%0d_bad", i), 32'(sbad), tbl[i].exp_bad);
      chk($sformatf("vec%0d_drop", i), 32'(sdrop), tbl[i].exp_drop);
    end

    // 64-byte good frame: valid two cycles after the goodframe cycle.
    do_reset(0);
    ready = 1'b1;
    for (int i = 0; i < 64; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_lat_n1", 32'(sv), 0);
    step();
    chk("t1_lat_n2", 32'(sv), 1);
    wait_bytes(64, 200);
    check_frame("t1", 64, 8'h10);
    chk("t1_drop", 32'(sdrop), 0);
    chk("t1_bad", 32'(sbad), 0);

    // Bad frame discarded, following good frame intact.
    do_reset(0);
    ready = 1'b1;
    send_frame(60, 8'h30, 1'b1);
    repeat (5) step();
    chk("t2_no_out", q_data.size(), 0);
    chk("t2_bad", 32'(sbad), 1);
    send_frame(100, 8'h80, 1'b0);
    wait_bytes(100, 300);
    check_frame("t2", 100, 8'h80);
    chk("t2_bad_after", 32'(sbad), 1);
    chk("t2_drop", 32'(sdrop), 0);

    // 256-byte buffer, stalled client: second frame overflows and is dropped.
    do_reset(1);
    send_frame(200, 8'h01, 1'b0);
    send_frame(100, 8'h02, 1'b0);
    chk("t3_drop", 32'(sdrop), 1);
    chk("t3_bad", 32'(sbad), 0);
    ready = 1'b1;
    wait_bytes(200, 400);
    repeat (20) step();
    chk("t3_count", q_data.size(), 200);
    check_frame("t3", 200, 8'h01);

    // Oversize frame on the 256-byte buffer ends in drop; buffer usable afterwards.
    do_reset(1);
    ready = 1'b1;
    send_frame(300, 8'h03, 1'b0);
    chk("t4_drop", 32'(sdrop), 1);
    repeat (10) step();
    chk("t4_no_out", q_data.size(), 0);
    chk("t4_valid", 32'(sv), 0);
    send_frame(64, 8'h04, 1'b0);
    wait_bytes(64, 200);
    check_frame("t4", 64, 8'h04);

    // Two-entry length FIFO: the first frame's length is popped as soon as its first
    // byte loads, so frames 2 and 3 fill the FIFO and frame 4 is the one dropped.
    do_reset(2);
    send_frame(10, 8'h40, 1'b0);
    send_frame(10, 8'h50, 1'b0);
    send_frame(10, 8'h60, 1'b0);
    chk("t5_drop_3", 32'(sdrop), 0);
    send_frame(10, 8'h70, 1'b0);
    chk("t5_drop_4", 32'(sdrop), 1);
    ready = 1'b1;
    wait_bytes(30, 200);
    repeat (10) step();
    chk("t5_count", q_data.size(), 30);
    check_frame("t5a", 10, 8'h40);
    check_frame("t5b", 10, 8'h50);
    check_frame("t5c", 10, 8'h60);

    // Back-to-back frames with random backpressure.
    do_reset(0);
    rand_ready = 1'b1;
    total = 0;
    for (int f = 0; f < 20; f++) begin
      lens[f]  = $urandom_range(1, 40);
      seeds[f] = 8'($urandom_range(0, 255));
      total += lens[f];
      send_frame(lens[f], seeds[f], 1'b0);
    end
    wait_bytes(total, 5000);
    rand_ready = 1'b0;
    ready = 1'b1;
    repeat (5) step();
    chk("t6_count", q_data.size(), total);
    for (int f = 0; f < 20; f++) check_frame($sformatf("t6_f%0d", f), lens[f], seeds[f]);
    chk("t6_drop", 32'(sdrop), 0);

    // Reset while a byte is being presented.
    ready = 1'b0;
    send_frame(5, 8'h00, 1'b1);
    send_frame(20, 8'hC0, 1'b0);
    step();
    chk("t7_valid_pre", 32'(sv), 1);
    chk("t7_bad_pre", 32'(sbad), 1);
    reset = 1'b1;
    step();
    chk("t7_valid_rst", 32'(sv), 0);
    chk("t7_data_rst", 32'(sd), 0);
    chk("t7_bad_rst", 32'(sbad), 0);
    reset = 1'b0;
    ready = 1'b1;
    repeat (10) step();
    chk("t7_valid_after", 32'(sv), 0);
    chk("t7_no_out", q_data.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
